// File: rtl/hack_kbd_pkg.sv
// Hack keyboard definitions: Hack key codes, modifier scancodes and the
// scancode-set-2 to Hack key-code table.
package hack_kbd_pkg;

   localparam logic [7:0] KC_NEWLINE   = 8'd128;
   localparam logic [7:0] KC_BACKSPACE = 8'd129;
   localparam logic [7:0] KC_LEFT      = 8'd130;
   localparam logic [7:0] KC_UP        = 8'd131;
   localparam logic [7:0] KC_RIGHT     = 8'd132;
   localparam logic [7:0] KC_DOWN      = 8'd133;
   localparam logic [7:0] KC_HOME      = 8'd134;
   localparam logic [7:0] KC_END       = 8'd135;
   localparam logic [7:0] KC_PGUP      = 8'd136;
   localparam logic [7:0] KC_PGDN      = 8'd137;
   localparam logic [7:0] KC_INSERT    = 8'd138;
   localparam logic [7:0] KC_DELETE    = 8'd139;
   localparam logic [7:0] KC_ESC       = 8'd140;
   localparam logic [7:0] KC_F1        = 8'd141;
   localparam logic [7:0] KC_F12       = 8'd152;

   localparam logic [7:0] SC_LSHIFT = 8'h12;
   localparam logic [7:0] SC_RSHIFT = 8'h59;
   localparam logic [7:0] SC_CAPS   = 8'h58;

   // scan = {e0, code}; returns {mapped, hack_code}
   function automatic logic [8:0] hack_keymap(input logic [8:0] scan,
                                              input logic       upper,
                                              input logic       shift);
      logic [7:0] c;
      logic [7:0] s;
      c = 8'd0;
      s = 8'd0;
      case (scan)
         9'h01C: c = "a";   9'h032: c = "b";   9'h021: c = "c";
         9'h023: c = "d";   9'h024: c = "e";   9'h02B: c = "f";
         9'h034: c = "g";   9'h033: c = "h";   9'h043: c = "i";
         9'h03B: c = "j";   9'h042: c = "k";   9'h04B: c = "l";
         9'h03A: c = "m";   9'h031: c = "n";   9'h044: c = "o";
         9'h04D: c = "p";   9'h015: c = "q";   9'h02D: c = "r";
         9'h01B: c = "s";   9'h02C: c = "t";   9'h03C: c = "u";
         9'h02A: c = "v";   9'h01D: c = "w";   9'h022: c = "x";
         9'h035: c = "y";   9'h01A: c = "z";
         9'h016: begin c = "1"; s = "!"; end
         9'h01E: begin c = "2"; s = "@"; end
         9'h026: begin c = "3"; s = "#"; end
         9'h025: begin c = "4"; s = "$"; end
         9'h02E: begin c = "5"; s = "%"; end
         9'h036: begin c = "6"; s = "^"; end
         9'h03D: begin c = "7"; s = "&"; end
         9'h03E: begin c = "8"; s = "*"; end
         9'h046: begin c = "9"; s = "("; end
         9'h045: begin c = "0"; s = ")"; end
         9'h00E: begin c = 8'h60; s = "~"; end
         9'h04E: begin c = "-"; s = "_"; end
         9'h055: begin c = "="; s = "+"; end
         9'h054: begin c = "["; s = "{"; end
         9'h05B: begin c = "]"; s = "}"; end
         9'h05D: begin c = "\\"; s = "|"; end
         9'h04C: begin c = ";"; s = ":"; end
         9'h052: begin c = "'"; s = "\""; end
         9'h041: begin c = ","; s = "<"; end
         9'h049: begin c = "."; s = ">"; end
         9'h04A: begin c = "/"; s = "?"; end
         9'h029: c = " ";
         9'h05A, 9'h15A: c = KC_NEWLINE;
         9'h066: c = KC_BACKSPACE;
         9'h16B: c = KC_LEFT;
         9'h175: c = KC_UP;
         9'h174: c = KC_RIGHT;
         9'h172: c = KC_DOWN;
         9'h16C: c = KC_HOME;
         9'h169: c = KC_END;
         9'h17D: c = KC_PGUP;
         9'h17A: c = KC_PGDN;
         9'h170: c = KC_INSERT;
         9'h171: c = KC_DELETE;
         9'h076: c = KC_ESC;
         9'h005: c = KC_F1;
         9'h006: c = KC_F1 + 8'd1;
         9'h004: c = KC_F1 + 8'd2;
         9'h00C: c = KC_F1 + 8'd3;
         9'h003: c = KC_F1 + 8'd4;
         9'h00B: c = KC_F1 + 8'd5;
         9'h083: c = KC_F1 + 8'd6;
         9'h00A: c = KC_F1 + 8'd7;
         9'h001: c = KC_F1 + 8'd8;
         9'h009: c = KC_F1 + 8'd9;
         9'h078: c = KC_F1 + 8'd10;
         9'h007: c = KC_F12;
         default: c = 8'd0;
      endcase
      // letters follow shift^caps; other keys only shift, if they have a variant
      if (c >= "a" && c <= "z") begin
         if (upper) c = c - 8'd32;
      end else if (shift && s != 8'd0) begin
         c = s;
      end
      return {|c, c};
   endfunction

endpackage

// File: rtl/hack_ps2_keyboard_keymap_rom.sv
// Combinational scancode to Hack key-code lookup.
module hack_keymap_rom
   import hack_kbd_pkg::*;
(
   input  logic [8:0] scan,
   input  logic       upper,
   input  logic       shift,
   output logic [8:0] result
);

   always_comb result = hack_keymap(scan, upper, shift);

endmodule

// File: rtl/hack_ps2_keyboard.sv
// MiSTer ps2_key events to the Hack keyboard register: tracks modifiers
// and the most recently pressed key, output is that key's code while held.
module hack_ps2_keyboard
   import hack_kbd_pkg::*;
#(
   parameter bit CAPS_LOCK_EN = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [10:0] ps2_key,
   output logic [15:0] keyboard,
   output logic        key_strobe
);

   logic       tog_q;
   logic       lshift;
   logic       rshift;
   logic       caps;
   logic       held_valid;
   logic [8:0] held_scan;
   logic       ev;
   logic       pressed;
   logic [8:0] ev_scan;
   logic       shift;
   logic [8:0] s1_res;
   logic [8:0] s2_res;
   logic [15:0] next_kb;

   assign ev      = (ps2_key[10] != tog_q) & ~reset;
   assign pressed = ps2_key[9];
   assign ev_scan = ps2_key[8:0];
   assign shift   = lshift | rshift;

   hack_keymap_rom u_s1_rom (
      .scan   (ev_scan),
      .upper  (1'b0),
      .shift  (1'b0),
      .result (s1_res)
   );

   hack_keymap_rom u_s2_rom (
      .scan   (held_scan),
      .upper  (shift ^ caps),
      .shift  (shift),
      .result (s2_res)
   );

   always_comb begin
      next_kb = 16'd0;
      if (held_valid && s2_res[8]) next_kb = {8'd0, s2_res[7:0]};
   end

   always_ff @(posedge clk) begin
      tog_q <= ps2_key[10];
      if (reset) begin
         keyboard   <= 16'd0;
         key_strobe <= 1'b0;
         held_valid <= 1'b0;
         held_scan  <= 9'd0;
         lshift     <= 1'b0;
         rshift     <= 1'b0;
         caps       <= 1'b0;
      end else begin
         keyboard   <= next_kb;
         key_strobe <= (next_kb != keyboard);
         if (ev) begin
            if (ev_scan == {1'b0, SC_LSHIFT}) begin
               lshift <= pressed;
            end else if (ev_scan == {1'b0, SC_RSHIFT}) begin
               rshift <= pressed;
            end else if (ev_scan == {1'b0, SC_CAPS}) begin
               if (CAPS_LOCK_EN && pressed) caps <= ~caps;
            end else if (pressed) begin
               // every mapped code is nonzero, so a zero result means unmapped
               if (|s1_res) begin
                  held_scan  <= ev_scan;
                  held_valid <= 1'b1;
               end
            end else if (ev_scan == held_scan) begin
               held_valid <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_hack_ps2_keyboard.sv
// Scoreboard bench for hack_ps2_keyboard: each stimulus queues the keyboard
// value expected at the next strobe, a monitor pops on every key_strobe.
module tb_hack_ps2_keyboard;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [10:0] ps2_key = 11'd0;
   logic [15:0] keyboard;
   logic        key_strobe;

   int compared = 0;
   int mismatched = 0;
   logic [15:0] exp_q[$];

   hack_ps2_keyboard #(.CAPS_LOCK_EN(1'b1)) dut (
      .clk        (clk),
      .reset      (reset),
      .ps2_key    (ps2_key),
      .keyboard   (keyboard),
      .key_strobe (key_strobe)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] act,
                        input logic [15:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   // monitor: every strobe must match the oldest queued expectation
   always @(negedge clk) begin
      if (key_strobe === 1'b1) begin
         if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_strobe: got keyboard=%0d, expected no strobe",
                     keyboard);
         end else begin
            check("strobe_value", keyboard, exp_q.pop_front());
         end
      end
   end

   task automatic send(input logic p, input logic e, input logic [7:0] code);
      ps2_key = {~ps2_key[10], p, e, code};
      repeat (4) @(negedge clk);
   endtask

   task automatic mk(input logic e, input logic [7:0] code);
      send(1'b1, e, code);
   endtask

   task automatic brk(input logic e, input logic [7:0] code);
      send(1'b0, e, code);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("reset_keyboard", keyboard, 16'd0);
      check("reset_strobe", {15'd0, key_strobe}, 16'd0);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("idle_after_reset", keyboard, 16'd0);

      // 1: latency and basic make/break
      exp_q.push_back(16'd97);
      ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h1C};
      @(posedge clk); #1;
      check("latency_edge1", keyboard, 16'd0);
      @(posedge clk); #1;
      check("latency_edge2", keyboard, 16'd97);
      repeat (3) @(negedge clk);
      exp_q.push_back(16'd0);  brk(1'b0, 8'h1C);

      // 2: shift and caps
      mk(1'b0, 8'h12);
      exp_q.push_back(16'd65); mk(1'b0, 8'h1C);
      exp_q.push_back(16'd97); brk(1'b0, 8'h12);
      exp_q.push_back(16'd65); mk(1'b0, 8'h58);
      mk(1'b0, 8'h1C);
      brk(1'b0, 8'h58);
      exp_q.push_back(16'd97); mk(1'b0, 8'h58);
      exp_q.push_back(16'd0);  brk(1'b0, 8'h1C);

      // 3: newest key wins, stale break ignored
      exp_q.push_back(16'd97); mk(1'b0, 8'h1C);
      exp_q.push_back(16'd98); mk(1'b0, 8'h32);
      brk(1'b0, 8'h1C);
      check("stale_break_hold", keyboard, 16'd98);
      exp_q.push_back(16'd0);  brk(1'b0, 8'h32);

      // 4: extended keys, keypad codes unmapped
      exp_q.push_back(16'd130); mk(1'b1, 8'h6B);
      mk(1'b0, 8'h6B);
      check("keypad_unmapped", keyboard, 16'd130);
      exp_q.push_back(16'd0);   brk(1'b1, 8'h6B);
      exp_q.push_back(16'd139); mk(1'b1, 8'h71);
      exp_q.push_back(16'd0);   brk(1'b1, 8'h71);
      mk(1'b1, 8'h12);
      check("fake_shift_unmapped", keyboard, 16'd0);
      exp_q.push_back(16'd128); mk(1'b1, 8'h5A);
      exp_q.push_back(16'd152); mk(1'b0, 8'h07);
      exp_q.push_back(16'd32);  mk(1'b0, 8'h29);
      exp_q.push_back(16'd0);   brk(1'b0, 8'h29);

      // 5: two shifts
      mk(1'b0, 8'h12);
      mk(1'b0, 8'h59);
      brk(1'b0, 8'h12);
      exp_q.push_back(16'd33); mk(1'b0, 8'h16);
      exp_q.push_back(16'd49); brk(1'b0, 8'h59);
      exp_q.push_back(16'd0);  brk(1'b0, 8'h16);

      // 6: reset while held, toggle during reset dropped
      exp_q.push_back(16'd97); mk(1'b0, 8'h1C);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h1C};
      repeat (2) @(negedge clk);
      reset = 1'b0;
      check("cleared_by_reset", keyboard, 16'd0);
      repeat (4) @(negedge clk);
      check("no_event_after_reset", keyboard, 16'd0);
      mk(1'b0, 8'h7E);
      check("unmapped_7e", keyboard, 16'd0);

      repeat (4) @(negedge clk);
      check("queue_drained", 16'(exp_q.size()), 16'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish, expected completion");
      $fatal(1);
   end

endmodule
